alu_uart_interface: RTL and testbench

//  Command-side responder between uart_rx/uart_tx and the ALU. It collects a 3-byte frame
//  (A, B, OP) from the receiver and presents the operands to the ALU. It then captures
//  the result and hands it to the transmitter as one byte, with a strobe/done handshake.
//  It sits inside the top-level UART-ALU design and answers each frame the host sends.

---
 rtl/alu_defs_pkg.sv | 26 ++
 rtl/alu_uart_interface.sv | 153 +++++++++++++++
 tb/tb_alu_uart_interface.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: data/opcode widths, supported opcodes and the
// responder FSM state encoding.
package alu_defs;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_e;

endpackage

// File: rtl/alu_uart_interface.sv
// Frame responder between the UART and an external ALU: collects A, B, OP,
// presents the operands, then hands the registered result to uart_tx.
module alu_uart_interface #(
    parameter int NB_DATA       = alu_defs::NB_DATA,
    parameter int NB_OP         = alu_defs::NB_OP,
    parameter int TIMEOUT_TICKS = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_op_error,
    output logic               o_overrun
);

    import alu_defs::*;

    localparam int               CNT_W      = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam bit               TIMEOUT_EN = (TIMEOUT_TICKS != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_TICKS - 1);

    state_e               state_q, state_d;
    logic [NB_DATA-1:0]   alu_a_q, alu_a_d;
    logic [NB_DATA-1:0]   alu_b_q, alu_b_d;
    logic [NB_OP-1:0]     alu_op_q, alu_op_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_error_q, op_error_d;
    logic                 overrun_q, overrun_d;
    logic                 collecting;
    logic                 timeout_hit;
    logic                 op_ok;
    logic [NB_OP-1:0]     rx_op;

    function automatic logic op_valid(input logic [NB_OP-1:0] op);
        logic ok;
        ok = 1'b0;
        if (op == NB_OP'(OP_ADD) || op == NB_OP'(OP_SUB) ||
            op == NB_OP'(OP_AND) || op == NB_OP'(OP_OR)  ||
            op == NB_OP'(OP_XOR) || op == NB_OP'(OP_NOR) ||
            op == NB_OP'(OP_SRA) || op == NB_OP'(OP_SRL))
            ok = 1'b1;
        return ok;
    endfunction

    assign rx_op       = i_rx_data[NB_OP-1:0];
    assign op_ok       = op_valid(rx_op);
    assign collecting  = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
    // An incoming byte always wins over an expiring timeout in the same cycle.
    assign timeout_hit = TIMEOUT_EN && collecting && !i_rx_done && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            cnt_q      <= '0;
            op_error_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            cnt_q      <= cnt_d;
            op_error_q <= op_error_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done) state_d = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (i_rx_done)        state_d = ST_WAIT_OP;
                else if (timeout_hit) state_d = ST_WAIT_A;
            end
            ST_WAIT_OP: begin
                if (i_rx_done)        state_d = op_ok ? ST_COMPUTE : ST_WAIT_A;
                else if (timeout_hit) state_d = ST_WAIT_A;
            end
            ST_COMPUTE: state_d = ST_SEND;
            ST_SEND:    state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (i_tx_done) state_d = ST_WAIT_A;
            end
            default:    state_d = ST_WAIT_A;
        endcase
    end

    // Operand/result capture, error pulses and the inter-byte counter.
    always_comb begin
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        cnt_d      = '0;
        op_error_d = 1'b0;
        overrun_d  = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done) alu_a_d = i_rx_data;
            end
            ST_WAIT_B: begin
                if (i_rx_done)
                    alu_b_d = i_rx_data;
                else if (TIMEOUT_EN && !timeout_hit)
                    cnt_d = cnt_q + 1'b1;
            end
            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    if (op_ok) alu_op_d   = rx_op;
                    else       op_error_d = 1'b1;
                end else if (TIMEOUT_EN && !timeout_hit) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMPUTE: begin
                tx_data_d = i_alu_result;
                overrun_d = i_rx_done;
            end
            ST_SEND:    overrun_d = i_rx_done;
            ST_WAIT_TX: overrun_d = i_rx_done;
            default:    ;
        endcase
    end

    always_comb begin
        o_busy     = (state_q != ST_WAIT_A);
        o_tx_start = (state_q == ST_SEND);
        o_alu_a    = alu_a_q;
        o_alu_b    = alu_b_q;
        o_alu_op   = alu_op_q;
        o_tx_data  = tx_data_q;
        o_op_error = op_error_q;
        o_overrun  = overrun_q;
    end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed scoreboard bench for alu_uart_interface with a behavioural ALU
// closing the loop between o_alu_* and i_alu_result.
module tb_alu_uart_interface;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TICKS   = 16;

    logic               clk = 1'b0;
    logic               i_reset;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               i_tx_done;
    logic               o_busy;
    logic               o_op_error;
    logic               o_overrun;

    int checks   = 0;
    int failures = 0;
    logic [NB_DATA-1:0] exp_q[$];

    alu_uart_interface #(
        .NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_TICKS(TICKS)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
        .i_alu_result(i_alu_result),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_busy(o_busy), .o_op_error(o_op_error), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    // External ALU stand-in.
    always_comb begin
        case (o_alu_op)
            6'h20:   i_alu_result = o_alu_a + o_alu_b;
            6'h22:   i_alu_result = o_alu_a - o_alu_b;
            6'h24:   i_alu_result = o_alu_a & o_alu_b;
            6'h25:   i_alu_result = o_alu_a | o_alu_b;
            6'h26:   i_alu_result = o_alu_a ^ o_alu_b;
            6'h27:   i_alu_result = ~(o_alu_a | o_alu_b);
            6'h03:   i_alu_result = $signed(o_alu_a) >>> o_alu_b;
            6'h02:   i_alu_result = o_alu_a >> o_alu_b;
            default: i_alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                              input logic [7:0] expect_res);
        exp_q.push_back(expect_res);
        send_byte(a);
        send_byte(b);
        send_byte(op);
    endtask

    // Waits (bounded) for o_tx_start, checks latency, one-cycle width and data.
    task automatic expect_tx(input string tag);
        int n;
        logic [7:0] e;
        n = 0;
        while (!o_tx_start && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, o_tx_data, e);
            tick();
            check({tag, "_start_width"}, o_tx_start, 0);
            check({tag, "_busy_wait_tx"}, o_busy, 1);
            check({tag, "_data_hold"}, o_tx_data, e);
        end
    endtask

    task automatic finish_tx(input string tag);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check({tag, "_idle"}, o_busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, o_alu_a, 0);
        check({tag, "_b"}, o_alu_b, 0);
        check({tag, "_op"}, o_alu_op, 0);
        check({tag, "_txd"}, o_tx_data, 0);
        check({tag, "_start"}, o_tx_start, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_err"}, o_op_error, 0);
        check({tag, "_ovr"}, o_overrun, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        i_reset   = 1'b0;
        i_rx_data = '0;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        i_reset = 1'b1;
        tick();

        // Test 1: ADD
        send_frame(8'h43, 8'h21, 8'h20, 8'h64);
        check("t1_op", o_alu_op, 6'h20);
        check("t1_a", o_alu_a, 8'h43);
        check("t1_b", o_alu_b, 8'h21);
        check("t1_start_early", o_tx_start, 0);
        expect_tx("t1");
        finish_tx("t1");
        check("t1_a_hold", o_alu_a, 8'h43);

        // Test 2: SUB with wrap
        send_frame(8'h10, 8'h30, 8'h22, 8'hE0);
        expect_tx("t2");
        finish_tx("t2");

        // Test 3: unsupported opcode
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h3F);
        check("t3_err_pulse", o_op_error, 1);
        check("t3_idle", o_busy, 0);
        check("t3_op_kept", o_alu_op, 6'h22);
        tick();
        check("t3_err_width", o_op_error, 0);
        check("t3_no_start", o_tx_start, 0);
        send_frame(8'h0C, 8'h03, 8'h25, 8'h0F);
        expect_tx("t3b");
        finish_tx("t3b");

        // Test 4: timeout after A only, then fresh AND frame
        send_byte(8'h99);
        repeat (TICKS - 1) tick();
        check("t4_busy_before_expiry", o_busy, 1);
        tick();
        check("t4_timeout_idle", o_busy, 0);
        check("t4_no_err", o_op_error, 0);
        send_frame(8'h05, 8'h03, 8'h24, 8'h01);
        expect_tx("t4");
        finish_tx("t4");

        // Test 4b: byte arriving in the expiry cycle is accepted
        exp_q.push_back(8'h06);
        send_byte(8'h0C);
        repeat (TICKS - 1) tick();
        send_byte(8'h0A);
        check("t4b_accepted", o_busy, 1);
        check("t4b_b", o_alu_b, 8'h0A);
        send_byte(8'h26);
        expect_tx("t4b");
        finish_tx("t4b");

        // Test 5: overrun in WAIT_TX, then frame with ignored high OP bits
        send_frame(8'h50, 8'h0A, 8'h20, 8'h5A);
        expect_tx("t5");
        send_byte(8'hAA);
        check("t5_ovr_pulse", o_overrun, 1);
        check("t5_busy", o_busy, 1);
        tick();
        check("t5_ovr_width", o_overrun, 0);
        check("t5_txd_unchanged", o_tx_data, 8'h5A);
        finish_tx("t5");
        send_frame(8'h07, 8'h20, 8'hE5, 8'h27);
        check("t5_op_low_bits", o_alu_op, 6'h25);
        expect_tx("t5b");
        // rx_done and tx_done together in WAIT_TX
        i_rx_data = 8'h77;
        i_rx_done = 1'b1;
        i_tx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        check("t5c_idle", o_busy, 0);
        check("t5c_ovr", o_overrun, 1);
        check("t5c_a_unchanged", o_alu_a, 8'h07);

        // Test 6: reset in WAIT_OP and in WAIT_TX
        tick();
        send_byte(8'h12);
        send_byte(8'h34);
        #2;
        i_reset = 1'b0;
        #1;
        check_all_zero("t6_rst_wait_op");
        #2;
        i_reset = 1'b1;
        tick();
        send_frame(8'h01, 8'h02, 8'h20, 8'h03);
        expect_tx("t6a");
        #2;
        i_reset = 1'b0;
        #1;
        check_all_zero("t6_rst_wait_tx");
        #2;
        i_reset = 1'b1;
        tick();
        send_frame(8'hF0, 8'h0F, 8'h27, 8'h00);
        expect_tx("t6b");
        finish_tx("t6b");
        check("t6_sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
